// File: rtl/reg_scoreboard_if.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_if
//
// Bundles the decode (issue) and writeback traffic of the register-busy
// scoreboard together with its status outputs.
//
//   master : pipeline side (drives issue_* / wb_*, observes status)
//   slave  : scoreboard side (observes issue_* / wb_*, drives status)
//
// Signals
//   issue_valid  decode presents an instruction
//   issue_rd     destination register of the issuing instruction
//   issue_rs1    source register 1
//   issue_rs2    source register 2
//   wb_valid     writeback completing this cycle
//   wb_rd        register being written back
//   stall        combinational; issue must be held
//   busy_vec     registered busy mask, bit i = register i pending
//   busy_count   registered population count of busy_vec
//   err_wb_idle  sticky; writeback hit a register that was not busy
// -----------------------------------------------------------------------------
interface reg_scoreboard_if #(
    parameter int ADDR_W = 5
);
    localparam int NREG = 1 << ADDR_W;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic [ADDR_W-1:0] issue_rs1;
    logic [ADDR_W-1:0] issue_rs2;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic              stall;
    logic [NREG-1:0]   busy_vec;
    logic [ADDR_W:0]   busy_count;
    logic              err_wb_idle;

    modport master (
        output issue_valid, issue_rd, issue_rs1, issue_rs2, wb_valid, wb_rd,
        input  stall, busy_vec, busy_count, err_wb_idle
    );

    modport slave (
        input  issue_valid, issue_rd, issue_rs1, issue_rs2, wb_valid, wb_rd,
        output stall, busy_vec, busy_count, err_wb_idle
    );
endinterface

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
//
// Register-busy scoreboard for the pipelined datapath. An accepted issue marks
// its destination register busy; the matching writeback frees it. Both source
// registers and the destination of the issuing instruction are compared
// against the busy mask to produce a combinational stall.
//
// Parameters
//   ADDR_W     register address width, NREG = 2**ADDR_W tracked registers
//   ZERO_REG   hardwired zero register, never busy and never stalls
//              (set to NREG to disable)
//   WB_BYPASS  1 = a writeback in the current cycle already un-busies its
//              register for stall evaluation
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   sb       reg_scoreboard_if.slave (issue / writeback / status)
// -----------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int ADDR_W    = 5,
    parameter int ZERO_REG  = 31,
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic            clk,
    input  logic            reset_n,
    reg_scoreboard_if.slave sb
);
    localparam int NREG = 1 << ADDR_W;
    localparam int CW   = ADDR_W + 1;

    // One-hot decode of a register address; generic in ADDR_W.
    function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [NREG-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // True when the address names the hardwired zero register. With
    // ZERO_REG >= NREG no address can match, which disables the feature.
    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG < NREG) && (int'(a) == ZERO_REG);
    endfunction

    // Architectural state.
    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;

    // Combinational helpers.
    logic [NREG-1:0] eb;        // effective busy seen by the stall compare
    logic            hit_rs1, hit_rs2, hit_rd;
    logic            stall;
    logic            accept;
    logic [NREG-1:0] set_oh;    // bit being marked busy this cycle
    logic [NREG-1:0] wb_oh;     // bit addressed by a non-zero writeback
    logic [NREG-1:0] clr_oh;    // writeback bits that really were busy
    logic            inc, dec;

    // -------------------------------------------------------------------------
    // Stall evaluation
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in an always_comb gets a default on
        // entry so no path leaves it unassigned, which would infer a latch.
        eb = busy_q;
        // With bypass, the register being written back this cycle is
        // already considered free, so its consumer can issue right now.
        if (WB_BYPASS && sb.wb_valid) begin
            eb[sb.wb_rd] = 1'b0;
        end

        hit_rs1 = eb[sb.issue_rs1] & ~is_zero(sb.issue_rs1);
        hit_rs2 = eb[sb.issue_rs2] & ~is_zero(sb.issue_rs2);
        hit_rd  = eb[sb.issue_rd]  & ~is_zero(sb.issue_rd);

        stall  = sb.issue_valid & (hit_rs1 | hit_rs2 | hit_rd);
        accept = sb.issue_valid & ~stall;
    end

    // -------------------------------------------------------------------------
    // Next-state for busy mask, count and sticky error
    // -------------------------------------------------------------------------
    always_comb begin
        set_oh = '0;
        wb_oh  = '0;
        if (accept && !is_zero(sb.issue_rd)) begin
            set_oh = onehot(sb.issue_rd);
        end
        if (sb.wb_valid && !is_zero(sb.wb_rd)) begin
            wb_oh = onehot(sb.wb_rd);
        end

        clr_oh = wb_oh & busy_q;

        // Set wins over clear: a same-cycle set+clear of one register (only
        // reachable with bypass) leaves the bit busy and the count unchanged.
        busy_d = (busy_q & ~clr_oh) | set_oh;

        inc = |(set_oh & ~busy_q);
        dec = |(clr_oh & ~set_oh);
        count_d = count_q + {{(CW-1){1'b0}}, inc} - {{(CW-1){1'b0}}, dec};

        // A writeback to a free register is a pipeline bookkeeping error;
        // the mask is left alone and the flag sticks until reset.
        err_d = err_q | (|(wb_oh & ~busy_q));
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: the busy mask is ordinary flip-flops, not a RAM, so it is cleared
    // by reset; that reset is what discards in-flight work on a flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values, independent of statement order.
            busy_q  <= busy_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign sb.stall       = stall;
    assign sb.busy_vec    = busy_q;
    assign sb.busy_count  = count_q;
    assign sb.err_wb_idle = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_scoreboard
//
// Two scoreboards side by side: dut0 without writeback bypass, dut1 with it.
// The stimulus process drives one cycle at a time and pushes the response it
// expects for that cycle into a queue; a separate monitor samples the DUT on
// the falling edge and pops/compares every expectation due by that cycle.
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;

    localparam int ADDR_W = 5;

    logic clk;
    logic reset_n;
    int   cyc;

    reg_scoreboard_if #(.ADDR_W(ADDR_W)) ifc0 ();
    reg_scoreboard_if #(.ADDR_W(ADDR_W)) ifc1 ();

    reg_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(31), .WB_BYPASS(1'b0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .sb      (ifc0.slave)
    );

    reg_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(31), .WB_BYPASS(1'b1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .sb      (ifc1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    typedef struct {
        int          cyc;
        int          dut;
        string       name;
        logic        stall;
        logic [31:0] vec;
        int          cnt;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic ok, input string got,
                         input string want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, expected %s", name, got, want);
    endtask

    task automatic expect_now(input string name, input int dut, input logic st,
                              input logic [31:0] vec, input int cnt,
                              input logic err);
        exp_t e;
        e.cyc = cyc; e.dut = dut; e.name = name;
        e.stall = st; e.vec = vec; e.cnt = cnt; e.err = err;
        exp_q.push_back(e);
    endtask

    // Monitor: compare everything due at or before the current cycle.
    exp_t        m_e;
    logic        m_stall, m_err;
    logic [31:0] m_vec;
    logic [5:0]  m_cnt;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            m_e = exp_q.pop_front();
            if (m_e.dut == 0) begin
                m_stall = ifc0.stall; m_vec = ifc0.busy_vec;
                m_cnt = ifc0.busy_count; m_err = ifc0.err_wb_idle;
            end else begin
                m_stall = ifc1.stall; m_vec = ifc1.busy_vec;
                m_cnt = ifc1.busy_count; m_err = ifc1.err_wb_idle;
            end
            check($sformatf("%s[dut%0d]", m_e.name, m_e.dut),
                  (m_stall === m_e.stall) && (m_vec === m_e.vec) &&
                  (int'(m_cnt) == m_e.cnt) && (m_err === m_e.err),
                  $sformatf("stall=%b vec=%h cnt=%0d err=%b",
                            m_stall, m_vec, m_cnt, m_err),
                  $sformatf("stall=%b vec=%h cnt=%0d err=%b",
                            m_e.stall, m_e.vec, m_e.cnt, m_e.err));
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int dut, input logic iv, input int rd,
                         input int rs1, input int rs2, input logic wv,
                         input int wrd);
        if (dut == 0) begin
            ifc0.issue_valid = iv;
            ifc0.issue_rd    = ADDR_W'(rd);
            ifc0.issue_rs1   = ADDR_W'(rs1);
            ifc0.issue_rs2   = ADDR_W'(rs2);
            ifc0.wb_valid    = wv;
            ifc0.wb_rd       = ADDR_W'(wrd);
        end else begin
            ifc1.issue_valid = iv;
            ifc1.issue_rd    = ADDR_W'(rd);
            ifc1.issue_rs1   = ADDR_W'(rs1);
            ifc1.issue_rs2   = ADDR_W'(rs2);
            ifc1.wb_valid    = wv;
            ifc1.wb_rd       = ADDR_W'(wrd);
        end
    endtask

    // One clock: advance, drive, record what must be observed this cycle.
    task automatic step(input int dut, input logic iv, input int rd,
                        input int rs1, input int rs2, input logic wv,
                        input int wrd, input string name, input logic st,
                        input logic [31:0] vec, input int cnt, input logic err);
        tick();
        drive(dut, iv, rd, rs1, rs2, wv, wrd);
        expect_now(name, dut, st, vec, cnt, err);
    endtask

    // -------------------------------------------------------------------------
    // Directed vectors
    // -------------------------------------------------------------------------
    initial begin
        logic [31:0] v;
        reset_n = 1'b0;
        drive(0, 1'b0, 0, 0, 0, 1'b0, 0);
        drive(1, 1'b0, 0, 0, 0, 1'b0, 0);
        tick();
        tick();
        reset_n = 1'b1;
        expect_now("reset_init", 0, 1'b0, 32'h0, 0, 1'b0);
        expect_now("reset_init", 1, 1'b0, 32'h0, 0, 1'b0);

        // ---- dut0: dependency and writeback without bypass ----
        step(0, 1, 3, 0, 0, 0, 0,  "issue_rd3",      0, 32'h0,  0, 0);
        step(0, 1, 4, 3, 0, 0, 0,  "raw_rs1_stall",  1, 32'h8,  1, 0);
        step(0, 1, 4, 3, 0, 1, 3,  "wb_nobypass",    1, 32'h8,  1, 0);
        step(0, 1, 4, 3, 0, 0, 0,  "consumer_go",    0, 32'h0,  0, 0);
        step(0, 0, 0, 0, 0, 0, 0,  "rd4_busy",       0, 32'h10, 1, 0);
        step(0, 1, 7, 31, 4, 1, 4, "raw_rs2_stall",  1, 32'h10, 1, 0);
        step(0, 1, 7, 31, 4, 0, 0, "rs2_go",         0, 32'h0,  0, 0);
        step(0, 1, 7, 31, 31, 0, 0, "waw_rd_stall",  1, 32'h80, 1, 0);
        step(0, 0, 0, 0, 0, 1, 7,  "wb_rd7",         0, 32'h80, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0,  "empty",          0, 32'h0,  0, 0);

        // ---- dut0: zero register never busy, never stalls ----
        step(0, 1, 31, 31, 31, 1, 31, "zero_a",      0, 32'h0,  0, 0);
        step(0, 1, 31, 31, 31, 1, 31, "zero_b",      0, 32'h0,  0, 0);
        step(0, 0, 0, 0, 0, 0, 0,  "zero_after",     0, 32'h0,  0, 0);

        // ---- dut0: fill every non-zero register ----
        for (int i = 0; i < 31; i++) begin
            v = (32'h1 << i) - 32'h1;
            step(0, 1, i, 31, 31, 0, 0, $sformatf("fill_%0d", i), 0, v, i, 0);
        end
        step(0, 1, 5, 31, 31, 0, 0, "full_stall",   1, 32'h7FFF_FFFF, 31, 0);
        for (int i = 0; i < 31; i++) begin
            v = 32'h7FFF_FFFF & ~((32'h1 << i) - 32'h1);
            step(0, 0, 0, 0, 0, 1, i, $sformatf("drain_%0d", i), 0, v, 31 - i, 0);
        end
        step(0, 0, 0, 0, 0, 0, 0,  "drained",        0, 32'h0,  0, 0);

        // ---- dut0: writeback to an idle register ----
        step(0, 0, 0, 0, 0, 1, 7,  "idle_wb",        0, 32'h0,  0, 0);
        step(0, 0, 0, 0, 0, 0, 0,  "err_set",        0, 32'h0,  0, 1);
        step(0, 0, 0, 0, 0, 0, 0,  "err_sticky",     0, 32'h0,  0, 1);

        // ---- dut0: asynchronous reset with registers 1 and 2 pending ----
        step(0, 1, 1, 31, 31, 0, 0, "pre_rst_a",     0, 32'h0,  0, 1);
        step(0, 1, 2, 31, 31, 0, 0, "pre_rst_b",     0, 32'h2,  1, 1);
        step(0, 0, 0, 0, 0, 0, 0,  "pre_rst_c",      0, 32'h6,  2, 1);
        tick();
        drive(0, 1'b1, 9, 31, 31, 1'b0, 0);
        #1;
        reset_n = 1'b0;
        expect_now("async_reset", 0, 1'b0, 32'h0, 0, 1'b0);
        step(0, 1, 9, 31, 31, 0, 0, "in_reset",      0, 32'h0,  0, 0);
        tick();
        drive(0, 1'b0, 0, 0, 0, 1'b0, 0);
        reset_n = 1'b1;
        expect_now("post_reset", 0, 1'b0, 32'h0, 0, 1'b0);

        // ---- dut1: same-cycle writeback bypass ----
        step(1, 1, 3, 0, 0, 0, 0,  "b_issue_rd3",    0, 32'h0,  0, 0);
        step(1, 1, 4, 3, 0, 1, 3,  "b_bypass_go",    0, 32'h8,  1, 0);
        step(1, 0, 0, 0, 0, 0, 0,  "b_swap",         0, 32'h10, 1, 0);
        step(1, 0, 0, 0, 0, 1, 4,  "b_wb4",          0, 32'h10, 1, 0);
        step(1, 1, 5, 31, 31, 0, 0, "b_issue_rd5",   0, 32'h0,  0, 0);
        step(1, 1, 5, 31, 31, 1, 5, "b_set_clr",     0, 32'h20, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0,  "b_set_wins",     0, 32'h20, 1, 0);
        step(1, 0, 0, 0, 0, 1, 5,  "b_wb5",          0, 32'h20, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0,  "b_empty",        0, 32'h0,  0, 0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
        while (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            check({"unchecked_", m_e.name}, 1'b0, "no sample", "sampled");
        end
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
